// File: rtl/fp_divide_iterative.sv
// Single-precision IEEE-754 divider (out = in1 / in2) built as a multi-cycle restoring divider.
// Denormals are flushed to zero; one operation is in flight at a time behind an accept handshake.
module fp_divide_iterative (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_data_in,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [2:0]  rounding_mode,
  output logic        in_ready,
  output logic [31:0] out,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact,
  output logic        invalid_operation,
  output logic        divide_by_zero,
  output logic        valid_data_out
);

  localparam int unsigned QBITS = 26;
  localparam int unsigned CW    = 5;
  localparam int unsigned EW    = 10;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  typedef enum logic [1:0] {IDLE, SPECIAL, DIVIDE, ROUND} state_t;

  state_t          state;
  logic [25:0]     rem;
  logic [23:0]     mb;
  logic [24:0]     q;
  logic [CW-1:0]   cnt;
  logic [EW-1:0]   exp_r;
  logic            sign_r;
  logic [2:0]      rm_r;
  logic [31:0]     spec_res_r;
  logic            spec_uf_r;
  logic            spec_inv_r;
  logic            spec_dbz_r;

  // Operand classification
  logic [7:0]  e1, e2;
  logic [22:0] m1, m2;
  logic        z1, z2, f1, f2, inf1, inf2, qn1, qn2, sn1, sn2, sgn_in;

  assign e1     = in1[30:23];
  assign e2     = in2[30:23];
  assign m1     = in1[22:0];
  assign m2     = in2[22:0];
  assign z1     = (e1 == 8'd0);
  assign z2     = (e2 == 8'd0);
  assign f1     = z1 & (m1 != 23'd0);
  assign f2     = z2 & (m2 != 23'd0);
  assign inf1   = (e1 == 8'hFF) & (m1 == 23'd0);
  assign inf2   = (e2 == 8'hFF) & (m2 == 23'd0);
  assign qn1    = (e1 == 8'hFF) & m1[22];
  assign qn2    = (e2 == 8'hFF) & m2[22];
  assign sn1    = (e1 == 8'hFF) & ~m1[22] & (m1 != 23'd0);
  assign sn2    = (e2 == 8'hFF) & ~m2[22] & (m2 != 23'd0);
  assign sgn_in = in1[31] ^ in2[31];

  // Special-case result selection in priority order
  logic        is_spec;
  logic [31:0] spec_res;
  logic        spec_inv;
  logic        spec_dbz;

  always_comb begin
    is_spec  = 1'b1;
    spec_res = 32'd0;
    spec_inv = 1'b0;
    spec_dbz = 1'b0;
    if (qn1) begin
      spec_res = in1;
    end else if (qn2) begin
      spec_res = in2;
    end else if (sn1) begin
      spec_res = in1 | 32'h0040_0000;
      spec_inv = 1'b1;
    end else if (sn2) begin
      spec_res = in2 | 32'h0040_0000;
      spec_inv = 1'b1;
    end else if ((z1 & z2) | (inf1 & inf2)) begin
      spec_res = 32'h7FC0_0000;
      spec_inv = 1'b1;
    end else if (inf1) begin
      spec_res = {sgn_in, 8'hFF, 23'd0};
    end else if (inf2) begin
      spec_res = {sgn_in, 31'd0};
    end else if (z2) begin
      spec_res = {sgn_in, 8'hFF, 23'd0};
      spec_dbz = 1'b1;
    end else if (z1) begin
      spec_res = {sgn_in, 31'd0};
    end else begin
      is_spec  = 1'b0;
    end
  end

  // Normal-path setup: pre-normalise so the quotient lands in [1,2)
  logic [23:0]   ma, mb_in;
  logic          ma_lt;
  logic [25:0]   rem_init;
  logic [EW-1:0] exp_init;

  assign ma       = {1'b1, m1};
  assign mb_in    = {1'b1, m2};
  assign ma_lt    = (ma < mb_in);
  assign rem_init = ma_lt ? {1'b0, ma, 1'b0} : {2'b00, ma};
  assign exp_init = EW'(e1) - EW'(e2) + EW'(127) - EW'(ma_lt);

  // One restoring-division step
  logic        rem_ge;
  logic [25:0] rem_diff;
  logic [25:0] rem_next;

  assign rem_ge   = (rem >= {2'b00, mb});
  assign rem_diff = rem_ge ? (rem - {2'b00, mb}) : rem;
  assign rem_next = {rem_diff[24:0], 1'b0};

  // Rounding; the always-one leading quotient bit has already shifted out of q
  logic [22:0]   mant;
  logic          g_bit, r_bit, s_bit, grs, inc;
  logic [23:0]   mant_sum;
  logic [EW-1:0] exp_rnd;
  logic          ovf, unf;
  logic [31:0]   ovf_res;
  logic [31:0]   round_res;

  assign mant     = q[24:2];
  assign g_bit    = q[1];
  assign r_bit    = q[0];
  assign s_bit    = (rem != 26'd0);
  assign grs      = g_bit | r_bit | s_bit;
  assign mant_sum = {1'b0, mant} + 24'(inc);
  assign exp_rnd  = exp_r + EW'(mant_sum[23]);
  assign ovf      = $signed(exp_rnd) > $signed(EW'(254));
  assign unf      = $signed(exp_rnd) <= $signed(EW'(0));

  always_comb begin
    inc = 1'b0;
    case (rm_r)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign_r & grs;
      RM_RUP:  inc = ~sign_r & grs;
      RM_RMM:  inc = g_bit;
      default: inc = g_bit & (r_bit | s_bit | mant[0]);
    endcase
  end

  always_comb begin
    ovf_res = {sign_r, 8'hFF, 23'd0};
    case (rm_r)
      RM_RTZ:  ovf_res = {sign_r, 31'h7F7F_FFFF};
      RM_RDN:  ovf_res = sign_r ? 32'hFF80_0000 : 32'h7F7F_FFFF;
      RM_RUP:  ovf_res = sign_r ? 32'hFF7F_FFFF : 32'h7F80_0000;
      default: ovf_res = {sign_r, 8'hFF, 23'd0};
    endcase
    if (ovf)
      round_res = ovf_res;
    else if (unf)
      round_res = {sign_r, 31'd0};
    else
      round_res = {sign_r, exp_rnd[7:0], mant_sum[22:0]};
  end

  // Control FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      in_ready          <= 1'b1;
      out               <= 32'd0;
      overflow          <= 1'b0;
      underflow         <= 1'b0;
      inexact           <= 1'b0;
      invalid_operation <= 1'b0;
      divide_by_zero    <= 1'b0;
      valid_data_out    <= 1'b0;
      rem               <= 26'd0;
      mb                <= 24'd0;
      q                 <= 25'd0;
      cnt               <= '0;
      exp_r             <= '0;
      sign_r            <= 1'b0;
      rm_r              <= 3'd0;
      spec_res_r        <= 32'd0;
      spec_uf_r         <= 1'b0;
      spec_inv_r        <= 1'b0;
      spec_dbz_r        <= 1'b0;
    end else begin
      valid_data_out <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_data_in) begin
            in_ready   <= 1'b0;
            sign_r     <= sgn_in;
            rm_r       <= rounding_mode;
            spec_res_r <= spec_res;
            spec_uf_r  <= is_spec & (f1 | f2);
            spec_inv_r <= spec_inv;
            spec_dbz_r <= spec_dbz;
            rem        <= rem_init;
            mb         <= mb_in;
            exp_r      <= exp_init;
            q          <= 25'd0;
            cnt        <= '0;
            state      <= is_spec ? SPECIAL : DIVIDE;
          end
        end
        SPECIAL: begin
          out               <= spec_res_r;
          overflow          <= 1'b0;
          underflow         <= spec_uf_r;
          inexact           <= 1'b0;
          invalid_operation <= spec_inv_r;
          divide_by_zero    <= spec_dbz_r;
          valid_data_out    <= 1'b1;
          in_ready          <= 1'b1;
          state             <= IDLE;
        end
        DIVIDE: begin
          rem <= rem_next;
          q   <= {q[23:0], rem_ge};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(QBITS - 1))
            state <= ROUND;
        end
        ROUND: begin
          out               <= round_res;
          overflow          <= ovf;
          underflow         <= ~ovf & unf;
          inexact           <= ovf | unf | grs;
          invalid_operation <= 1'b0;
          divide_by_zero    <= 1'b0;
          valid_data_out    <= 1'b1;
          in_ready          <= 1'b1;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divide_iterative.sv
// Self-checking bench for fp_divide_iterative: an arithmetic reference model plus a
// per-cycle checker of the handshake, latency, held outputs and literal expectations.
module tb_fp_divide_iterative;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_data_in = 1'b0;
  logic [31:0] in1 = 32'd0;
  logic [31:0] in2 = 32'd0;
  logic [2:0]  rounding_mode = 3'd0;
  logic        in_ready;
  logic [31:0] out;
  logic        overflow, underflow, inexact, invalid_operation, divide_by_zero;
  logic        valid_data_out;

  fp_divide_iterative dut (
    .clk(clk), .rst_n(rst_n), .valid_data_in(valid_data_in),
    .in1(in1), .in2(in2), .rounding_mode(rounding_mode),
    .in_ready(in_ready), .out(out),
    .overflow(overflow), .underflow(underflow), .inexact(inexact),
    .invalid_operation(invalid_operation), .divide_by_zero(divide_by_zero),
    .valid_data_out(valid_data_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int tmo_cnt = 0;
  int tmo_seen = 0;
  int ncyc = 0;
  int due = 0;
  bit pend = 1'b0;
  bit pend_lit = 1'b0;
  bit lit_en = 1'b0;
  bit exp_v;
  logic [36:0] lit_res = 37'd0;
  logic [36:0] pend_lit_res = 37'd0;
  logic [36:0] exp_res = 37'd0;
  logic [36:0] last_res = 37'd0;
  logic [37:0] mres;
  logic [36:0] dut_res;

  // Flags packed as {overflow, underflow, inexact, invalid, divide_by_zero}
  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_DBZ  = 5'b00001;
  localparam logic [4:0] F_INV  = 5'b00010;
  localparam logic [4:0] F_INX  = 5'b00100;
  localparam logic [4:0] F_UF   = 5'b01000;
  localparam logic [4:0] F_OVF  = 5'b10000;

  // Reference: classify, divide with wide integers, round from G/R/S. Bit 37 = special case.
  function automatic logic [37:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] rm);
    int ea, eb, e;
    longint ma, mb, num, qt, rmd, mant;
    bit za, zb, fla, flb, ia, ib, qa, qb, sa, sb, s, g, rr, st, grs, inc;
    logic [4:0] uf5;
    logic [31:0] res;
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    za  = (ea == 0);
    zb  = (eb == 0);
    fla = za && (a[22:0] != 0);
    flb = zb && (b[22:0] != 0);
    ia  = (ea == 255) && (a[22:0] == 0);
    ib  = (eb == 255) && (b[22:0] == 0);
    qa  = (ea == 255) && a[22];
    qb  = (eb == 255) && b[22];
    sa  = (ea == 255) && !a[22] && (a[22:0] != 0);
    sb  = (eb == 255) && !b[22] && (b[22:0] != 0);
    s   = a[31] ^ b[31];
    uf5 = (fla || flb) ? F_UF : F_NONE;
    if (qa) return {1'b1, uf5, a};
    if (qb) return {1'b1, uf5, b};
    if (sa) return {1'b1, uf5 | F_INV, a | 32'h0040_0000};
    if (sb) return {1'b1, uf5 | F_INV, b | 32'h0040_0000};
    if ((za && zb) || (ia && ib)) return {1'b1, uf5 | F_INV, 32'h7FC0_0000};
    if (ia) return {1'b1, uf5, s, 31'h7F80_0000};
    if (ib) return {1'b1, uf5, s, 31'h0};
    if (zb) return {1'b1, uf5 | F_DBZ, s, 31'h7F80_0000};
    if (za) return {1'b1, uf5, s, 31'h0};
    ma = (longint'(1) << 23) + longint'(a[22:0]);
    mb = (longint'(1) << 23) + longint'(b[22:0]);
    e  = ea - eb + 127;
    if (ma < mb) begin
      ma = ma * 2;
      e  = e - 1;
    end
    num  = ma << 25;
    qt   = num / mb;
    rmd  = num % mb;
    mant = (qt >> 2) & 64'h7F_FFFF;
    g    = ((qt >> 1) & 1) != 0;
    rr   = (qt & 1) != 0;
    st   = (rmd != 0);
    grs  = g || rr || st;
    case (rm)
      3'd1:    inc = 1'b0;
      3'd2:    inc = s && grs;
      3'd3:    inc = !s && grs;
      3'd4:    inc = g;
      default: inc = g && (rr || st || ((mant % 2) == 1));
    endcase
    if (inc) mant = mant + 1;
    if (mant == (longint'(1) << 23)) begin
      mant = 0;
      e = e + 1;
    end
    if (e > 254) begin
      case (rm)
        3'd1:    res = {s, 31'h7F7F_FFFF};
        3'd2:    res = s ? 32'hFF80_0000 : 32'h7F7F_FFFF;
        3'd3:    res = s ? 32'hFF7F_FFFF : 32'h7F80_0000;
        default: res = {s, 31'h7F80_0000};
      endcase
      return {1'b0, F_OVF | F_INX, res};
    end
    if (e <= 0) return {1'b0, F_UF | F_INX, s, 31'h0};
    res = {s, 8'(e), 23'(mant)};
    return {1'b0, grs ? F_INX : F_NONE, res};
  endfunction

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, ncyc);
    end
  endtask

  assign dut_res = {overflow, underflow, inexact, invalid_operation, divide_by_zero, out};

  // Per-cycle checker, sampled on the falling edge
  always @(negedge clk) begin
    ncyc++;
    if (tmo_cnt != tmo_seen) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: in_ready stayed 0, required 1 (cycle %0d)", ncyc);
      tmo_seen = tmo_cnt;
    end
    if (!rst_n) begin
      pend     = 1'b0;
      last_res = 37'd0;
      chk("reset_outputs", dut_res, 37'd0);
      chk("reset_valid", 37'(valid_data_out), 37'd0);
      chk("reset_in_ready", 37'(in_ready), 37'd1);
    end else begin
      exp_v = pend && (ncyc == due);
      chk("valid_data_out", 37'(valid_data_out), 37'(exp_v));
      chk("in_ready", 37'(in_ready), 37'(!pend || exp_v));
      if (exp_v) begin
        last_res = exp_res;
        pend     = 1'b0;
        if (pend_lit) chk("literal_result", dut_res, pend_lit_res);
      end
      chk("result_vs_model", dut_res, last_res);
      if (valid_data_in && in_ready && !pend) begin
        mres     = model(in1, in2, rounding_mode);
        exp_res  = mres[36:0];
        due      = ncyc + (mres[37] ? 1 : 27) + 1;
        pend     = 1'b1;
        pend_lit = lit_en;
        pend_lit_res = lit_res;
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) tmo_cnt++;
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                    input bit le, input logic [4:0] fl, input logic [31:0] r);
    wait_ready();
    lit_en  = le;
    lit_res = {fl, r};
    in1 = a;
    in2 = b;
    rounding_mode = rm;
    valid_data_in = 1'b1;
    @(posedge clk); #1;
    valid_data_in = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    op(32'h40C0_0000, 32'h4000_0000, 3'd0, 1, F_NONE, 32'h4040_0000);
    op(32'h3F80_0000, 32'h4040_0000, 3'd0, 1, F_INX,  32'h3EAA_AAAB);
    op(32'h3F80_0000, 32'h4040_0000, 3'd1, 1, F_INX,  32'h3EAA_AAAA);
    op(32'h3F80_0000, 32'h4040_0000, 3'd3, 1, F_INX,  32'h3EAA_AAAB);
    op(32'h3F80_0000, 32'h4040_0000, 3'd4, 1, F_INX,  32'h3EAA_AAAB);
    op(32'h3F80_0000, 32'h4040_0000, 3'd7, 1, F_INX,  32'h3EAA_AAAB);
    op(32'hBF80_0000, 32'h4040_0000, 3'd2, 1, F_INX,  32'hBEAA_AAAB);
    op(32'hBF80_0000, 32'h4040_0000, 3'd3, 1, F_INX,  32'hBEAA_AAAA);
    op(32'h3F80_0000, 32'h0000_0000, 3'd0, 1, F_DBZ,  32'h7F80_0000);
    op(32'h0000_0000, 32'h0000_0000, 3'd0, 1, F_INV,  32'h7FC0_0000);
    op(32'h7F80_0001, 32'h3F80_0000, 3'd0, 1, F_INV,  32'h7FC0_0001);
    op(32'h0000_0001, 32'h3F80_0000, 3'd0, 1, F_UF,   32'h0000_0000);
    op(32'h7FC1_2345, 32'h7F80_0001, 3'd0, 1, F_NONE, 32'h7FC1_2345);
    op(32'h3F80_0000, 32'h7FA0_0000, 3'd0, 1, F_INV,  32'h7FE0_0000);
    op(32'h7F80_0000, 32'hFF80_0000, 3'd0, 1, F_INV,  32'h7FC0_0000);
    op(32'hFF80_0000, 32'h4000_0000, 3'd0, 1, F_NONE, 32'hFF80_0000);
    op(32'h4000_0000, 32'hFF80_0000, 3'd0, 1, F_NONE, 32'h8000_0000);
    op(32'h8000_0000, 32'h4000_0000, 3'd0, 1, F_NONE, 32'h8000_0000);
    op(32'h0040_0000, 32'h0000_0000, 3'd0, 1, F_UF | F_INV, 32'h7FC0_0000);
    op(32'h7F00_0000, 32'h3E80_0000, 3'd0, 1, F_OVF | F_INX, 32'h7F80_0000);
    op(32'h7F00_0000, 32'h3E80_0000, 3'd1, 1, F_OVF | F_INX, 32'h7F7F_FFFF);
    op(32'hFF00_0000, 32'h3E80_0000, 3'd2, 1, F_OVF | F_INX, 32'hFF80_0000);
    op(32'hFF00_0000, 32'h3E80_0000, 3'd3, 1, F_OVF | F_INX, 32'hFF7F_FFFF);
    op(32'h0080_0000, 32'h4B00_0000, 3'd0, 1, F_UF | F_INX,  32'h0000_0000);
    op(32'h0100_0000, 32'h4000_0000, 3'd0, 1, F_NONE, 32'h0080_0000);
    op(32'h0080_0000, 32'h4000_0000, 3'd0, 1, F_UF | F_INX,  32'h0000_0000);
    for (int m = 0; m < 5; m++) begin
      op(32'h4049_0FDB, 32'h402D_F854, 3'(m), 0, F_NONE, 32'd0);
      op(32'h3FFF_FFFF, 32'h3F80_0001, 3'(m), 0, F_NONE, 32'd0);
      op(32'hFF7F_FFFF, 32'h0080_0000, 3'(m), 0, F_NONE, 32'd0);
    end

    // Reset in the middle of a divide, with an ignored request while busy
    op(32'h40C0_0000, 32'h4000_0000, 3'd0, 0, F_NONE, 32'd0);
    repeat (4) @(posedge clk); #1;
    in1 = 32'h3F80_0000;
    in2 = 32'h0000_0000;
    valid_data_in = 1'b1;
    @(posedge clk); #1;
    valid_data_in = 1'b0;
    repeat (4) @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk); #1;
    op(32'h40C0_0000, 32'h4000_0000, 3'd0, 1, F_NONE, 32'h4040_0000);

    wait_ready();
    repeat (3) @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
